// File: rtl/data_mem_responder_if.sv
// Load/store request bus between the core control path and the data-memory responder.
//   master : core side; drives MemRead, MemWrite, Funct3, Addr, WrData.
//   slave  : responder side; drives RdData, Stall, Done, AccErr.
interface data_mem_responder_if;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  Funct3;
    logic [31:0] Addr;
    logic [31:0] WrData;
    logic [31:0] RdData;
    logic        Stall;
    logic        Done;
    logic        AccErr;

    modport master (
        output MemRead, MemWrite, Funct3, Addr, WrData,
        input  RdData, Stall, Done, AccErr
    );

    modport slave (
        input  MemRead, MemWrite, Funct3, Addr, WrData,
        output RdData, Stall, Done, AccErr
    );
endinterface

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: word-organised memory with byte/half/word
// loads (sign/zero extended) and stores, fixed wait states, and error reporting.
//   clk   : clock, all state changes on the rising edge
//   reset : synchronous, active-high
//   bus   : slave side of the request bus (request in; RdData/Done/AccErr
//           registered, Stall combinational)
module data_mem_responder #(
    parameter int unsigned ADDR_W      = 9,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  bus
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned BA_W  = ADDR_W + 2;
    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BA_W-1:0]     addr_q, addr_d;
    logic [2:0]          f3_q, f3_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                rd_q, rd_d;
    logic                err_q, err_d;
    logic [31:0]         rdata_q;
    logic                done_q;
    logic                accerr_q;
    logic                access;

    logic [31:0]         mem_q [DEPTH];

    // Upper address bits do not select anything; addresses wrap.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.Addr[31:BA_W];

    // Request decode and error classification on the live bus.
    logic req, legal_f3, misalign, in_err;
    assign req      = bus.MemRead | bus.MemWrite;
    assign legal_f3 = bus.MemRead ? (bus.Funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                                  : (bus.Funct3 inside {3'b000, 3'b001, 3'b010});
    assign misalign = ((bus.Funct3[1:0] == 2'b01) && bus.Addr[0])
                   || ((bus.Funct3[1:0] == 2'b10) && (bus.Addr[1:0] != 2'b00));
    assign in_err   = !legal_f3 || misalign || (bus.MemRead && bus.MemWrite);

    // Next-state logic; the _d copies of the request fields are what the access uses,
    // so a zero-wait request is serviced straight from the bus.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        f3_d    = f3_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        err_d   = err_q;
        access  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    addr_d  = bus.Addr[BA_W-1:0];
                    f3_d    = bus.Funct3;
                    wdata_d = bus.WrData;
                    rd_d    = bus.MemRead;
                    err_d   = in_err;
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_DONE;
                        access  = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = S_DONE;
                    access  = 1'b1;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Load path: lane extraction and extension from the addressed word.
    logic [ADDR_W-1:0] widx;
    logic [31:0]       rd_word;
    logic [7:0]        byte_v;
    logic [15:0]       half_v;
    logic [31:0]       load_val;
    assign widx    = addr_d[BA_W-1:2];
    assign rd_word = mem_q[widx];
    assign byte_v  = 8'(rd_word >> {addr_d[1:0], 3'b000});
    assign half_v  = 16'(rd_word >> {addr_d[1], 4'b0000});

    always_comb begin
        load_val = 32'd0;
        case (f3_d)
            3'b000:  load_val = {{24{byte_v[7]}}, byte_v};
            3'b001:  load_val = {{16{half_v[15]}}, half_v};
            3'b010:  load_val = rd_word;
            3'b100:  load_val = {24'd0, byte_v};
            3'b101:  load_val = {16'd0, half_v};
            default: load_val = 32'd0;
        endcase
    end

    // Store path: replicate data across lanes, enable only the addressed ones.
    logic [31:0] wr_word;
    logic [3:0]  be;
    always_comb begin
        wr_word = wdata_d;
        be      = 4'b1111;
        case (f3_d[1:0])
            2'b00: begin
                wr_word = {4{wdata_d[7:0]}};
                be      = 4'(4'b0001 << addr_d[1:0]);
            end
            2'b01: begin
                wr_word = {2{wdata_d[15:0]}};
                be      = addr_d[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wr_word = wdata_d;
                be      = 4'b1111;
            end
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            f3_q     <= '0;
            wdata_q  <= '0;
            rd_q     <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= 32'd0;
            done_q   <= 1'b0;
            accerr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            f3_q     <= f3_d;
            wdata_q  <= wdata_d;
            rd_q     <= rd_d;
            err_q    <= err_d;
            done_q   <= access;
            accerr_q <= access & err_d;
            if (access && rd_d) begin
                rdata_q <= err_d ? 32'd0 : load_val;
            end
        end
    end

    // Memory array, not reset; reset in the completing cycle suppresses the write.
    always_ff @(posedge clk) begin
        if (!reset && access && !rd_d && !err_d) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_q[widx][8*i +: 8] <= wr_word[8*i +: 8];
                end
            end
        end
    end

    assign bus.RdData = rdata_q;
    assign bus.Done   = done_q;
    assign bus.AccErr = accerr_q;
    assign bus.Stall  = ((state_q == S_IDLE) && req) || (state_q == S_WAIT);

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    logic clk;
    logic reset;
    logic sel;   // 1: WAIT_CYCLES=2 instance, 0: WAIT_CYCLES=0 instance
    int   total;
    int   bad;

    data_mem_responder_if bus2 ();
    data_mem_responder_if bus0 ();

    data_mem_responder #(.ADDR_W(9), .WAIT_CYCLES(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2.slave)
    );

    data_mem_responder #(.ADDR_W(9), .WAIT_CYCLES(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        o_done, o_stall, o_err;
    logic [31:0] o_rd;
    assign o_done  = sel ? bus2.Done   : bus0.Done;
    assign o_stall = sel ? bus2.Stall  : bus0.Stall;
    assign o_err   = sel ? bus2.AccErr : bus0.AccErr;
    assign o_rd    = sel ? bus2.RdData : bus0.RdData;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        exp_err;
        logic        chk;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic rd, input logic wr,
                         input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        bus2.MemRead  = s ? rd : 1'b0;
        bus2.MemWrite = s ? wr : 1'b0;
        bus2.Funct3   = f3;
        bus2.Addr     = a;
        bus2.WrData   = wd;
        bus0.MemRead  = s ? 1'b0 : rd;
        bus0.MemWrite = s ? 1'b0 : wr;
        bus0.Funct3   = f3;
        bus0.Addr     = a;
        bus0.WrData   = wd;
    endtask

    // Issue one request at the current IDLE cycle, follow it to Done, then release.
    task automatic run_req(input logic s, input vec_t v, input string name);
        int   cyc;
        logic got;
        logic stall_ok;
        int   exp_lat;
        exp_lat = s ? 3 : 1;
        sel = s;
        drive(s, v.rd, v.wr, v.f3, v.addr, v.wd);
        #1;
        stall_ok = o_stall;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
            if (o_done) got = 1'b1;
            else if (!o_stall) stall_ok = 1'b0;
        end
        check({name, ".done"}, 32'(got), 32'd1);
        if (got) begin
            check({name, ".lat"}, 32'(cyc), 32'(exp_lat));
            check({name, ".stall"}, 32'(stall_ok), 32'd1);
            check({name, ".stall_done"}, 32'(o_stall), 32'd0);
            check({name, ".accerr"}, 32'(o_err), 32'(v.exp_err));
            if (v.chk) check({name, ".rdata"}, o_rd, v.exp_rd);
        end
        drive(s, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic seen;
        logic [2:0] dpat;
        total = 0;
        bad   = 0;
        sel   = 1'b1;
        reset = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst.rdata", bus2.RdData, 32'd0);
        check("rst.done", 32'(bus2.Done), 32'd0);
        check("rst.accerr", 32'(bus2.AccErr), 32'd0);
        check("rst.stall", 32'(bus2.Stall), 32'd0);
        check("rst0.done", 32'(bus0.Done), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        //              rd    wr    f3      addr          wdata         err   chk   exp_rd
        vecs.push_back('{1'b0, 1'b1, 3'b010, 32'h10,       32'hDEADBEEF, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 3'b010, 32'h10,       32'h0,        1'b0, 1'b1, 32'hDEADBEEF});
        vecs.push_back('{1'b0, 1'b1, 3'b010, 32'h10,       32'h0,        1'b0, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 1'b1, 3'b000, 32'h13,       32'h80,       1'b0, 1'b0, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 3'b000, 32'h13,       32'h0,        1'b0, 1'b1, 32'hFFFFFF80});
        vecs.push_back('{1'b1, 1'b0, 3'b100, 32'h13,       32'h0,        1'b0, 1'b1, 32'h00000080});
        vecs.push_back('{1'b1, 1'b0, 3'b010, 32'h10,       32'h0,        1'b0, 1'b1, 32'h80000000});
        vecs.push_back('{1'b0, 1'b1, 3'b010, 32'h20,       32'h12345678, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 1'b1, 3'b001, 32'h22,       32'h00008001, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 3'b001, 32'h22,       32'h0,        1'b0, 1'b1, 32'hFFFF8001});
        vecs.push_back('{1'b1, 1'b0, 3'b101, 32'h22,       32'h0,        1'b0, 1'b1, 32'h00008001});
        vecs.push_back('{1'b1, 1'b0, 3'b101, 32'h20,       32'h0,        1'b0, 1'b1, 32'h00005678});
        vecs.push_back('{1'b1, 1'b0, 3'b010, 32'h20,       32'h0,        1'b0, 1'b1, 32'h80015678});
        vecs.push_back('{1'b1, 1'b0, 3'b010, 32'h11,       32'h0,        1'b1, 1'b1, 32'h0});
        vecs.push_back('{1'b0, 1'b1, 3'b001, 32'h23,       32'hFFFF,     1'b1, 1'b1, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 3'b010, 32'h20,       32'h0,        1'b0, 1'b1, 32'h80015678});
        vecs.push_back('{1'b1, 1'b1, 3'b010, 32'h20,       32'h0,        1'b1, 1'b0, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 3'b010, 32'h20,       32'h0,        1'b0, 1'b1, 32'h80015678});
        vecs.push_back('{1'b1, 1'b0, 3'b011, 32'h20,       32'h0,        1'b1, 1'b1, 32'h0});
        vecs.push_back('{1'b0, 1'b1, 3'b100, 32'h20,       32'hFFFFFFFF, 1'b1, 1'b0, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 3'b010, 32'h20,       32'h0,        1'b0, 1'b1, 32'h80015678});
        vecs.push_back('{1'b0, 1'b1, 3'b010, 32'h840,      32'hCAFEF00D, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 3'b010, 32'h40,       32'h0,        1'b0, 1'b1, 32'hCAFEF00D});
        vecs.push_back('{1'b0, 1'b1, 3'b010, 32'h44,       32'h1,        1'b0, 1'b1, 32'hCAFEF00D});
        vecs.push_back('{1'b1, 1'b0, 3'b000, 32'h42,       32'h0,        1'b0, 1'b1, 32'hFFFFFFFE});
        vecs.push_back('{1'b1, 1'b0, 3'b101, 32'h42,       32'h0,        1'b0, 1'b1, 32'h0000CAFE});
        vecs.push_back('{1'b1, 1'b0, 3'b001, 32'hFFFF0040, 32'h0,        1'b0, 1'b1, 32'hFFFFF00D});
        vecs.push_back('{1'b1, 1'b0, 3'b100, 32'h41,       32'h0,        1'b0, 1'b1, 32'h000000F0});

        for (int i = 0; i < vecs.size(); i++) begin
            run_req(1'b1, vecs[i], $sformatf("v%0d", i));
        end

        // Reset in the completing WAIT cycle of a store: no write, no Done.
        run_req(1'b1, '{1'b0, 1'b1, 3'b010, 32'h30, 32'h11111111, 1'b0, 1'b0, 32'h0}, "rst_pre");
        sel = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 3'b010, 32'h30, 32'h22222222);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        seen = 1'b0;
        repeat (6) begin
            if (bus2.Done) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        check("rst_mid.no_done", 32'(seen), 32'd0);
        run_req(1'b1, '{1'b1, 1'b0, 3'b010, 32'h30, 32'h0, 1'b0, 1'b1, 32'h11111111}, "rst_post");

        // Zero wait states: single access, then two back-to-back loads held on the bus.
        run_req(1'b0, '{1'b0, 1'b1, 3'b010, 32'h8, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h0}, "w0_sw");
        run_req(1'b0, '{1'b1, 1'b0, 3'b010, 32'h8, 32'h0, 1'b0, 1'b1, 32'hA5A5A5A5}, "w0_lw");
        sel = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 3'b000, 32'hB, 32'h0);
        dpat = 3'b000;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            dpat[c] = o_done;
        end
        check("w0_b2b.done_pattern", 32'(dpat), 32'(3'b101));
        check("w0_b2b.rdata", o_rd, 32'hFFFFFFA5);
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Multi-cycle data-memory responder that services the load/store requests issued by the core's control path (MemRead/MemWrite) together with the instruction's funct3 field. It owns a word-organised internal memory and performs byte/half/word access with sign or zero extension. It asserts Stall while a request is in flight so the datapath freezes until the access completes. It sits between the ALU address output and the register-file write-back mux (MemtoReg = 1 path).

## Interface
Parameters:
- ADDR_W, 9: word-index width; memory depth = 2^ADDR_W 32-bit words.
- WAIT_CYCLES, 2: wait states inserted before each access, 0..15.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high.
- MemRead  input  1  load request; held stable by the core while Stall = 1.
- MemWrite  input  1  store request; held stable while Stall = 1.
- Funct3  input  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- Addr  input  32  byte address from the ALU.
- WrData  input  32  store data from register file read port 2.
- RdData  output  32  extended load result, registered.
- Stall  output  1  freeze PC/pipeline; combinational.
- Done  output  1  one-cycle pulse in the completing cycle.
- AccErr  output  1  one-cycle pulse with Done: misaligned, illegal funct3, or MemRead and MemWrite both high.

## Operation
- States: IDLE, WAIT, DONE. A counter of width 4 counts down wait states.
- IDLE:
  - With no request, stay in IDLE.
  - On MemRead | MemWrite: capture Addr, Funct3, WrData and the request type; load counter = WAIT_CYCLES.
  - Next state is WAIT, or DONE directly if WAIT_CYCLES = 0.
- WAIT: decrement the counter each cycle. When the counter = 1, go to DONE on the next edge. The access is performed on the edge that enters DONE.
- DONE: Done = 1 and Stall = 0. Unconditionally return to IDLE next cycle. The request present in the DONE cycle is the completing one and is not re-serviced.
- Word index = captured Addr[ADDR_W+1:2]. Upper address bits are ignored, so addresses wrap modulo 2^(ADDR_W+2) bytes.
- Loads:
  - Byte lane = Addr[1:0]; half lane = Addr[1].
  - b and h sign-extend; bu and hu zero-extend; w passes the word through.
  - RdData holds its value until the next DONE.
- Stores:
  - b writes WrData[7:0] into lane Addr[1:0].
  - h writes WrData[15:0] into the half selected by Addr[1].
  - w writes the full word.
  - Other lanes are unchanged.
  - RdData is unchanged by stores.
- Errors, detected at capture:
  - Any of these is an error: h/hu with Addr[0] = 1; w with Addr[1:0] ≠ 00; Funct3 ∉ {000, 001, 010, 100, 101} for loads or ∉ {000, 001, 010} for stores; MemRead and MemWrite both high.
  - On error, run the normal wait sequence but perform no memory write.
  - A failed load sets RdData = 0.
  - AccErr pulses together with Done.

## Timing
- Stall = (state == IDLE & (MemRead | MemWrite)) | (state == WAIT).
- Latency: request first seen in cycle 0 → Done in cycle WAIT_CYCLES + 1. Stall is high in cycles 0..WAIT_CYCLES.
- Back-to-back requests: the next request is accepted in the IDLE cycle right after DONE. Throughput is one access per WAIT_CYCLES + 2 cycles.
- Reset values: state IDLE, counter 0, RdData 0, Done 0, AccErr 0. Stall follows its equation, so it is 0 while reset is held with no request.
- Memory array contents are not reset.
- Reset asserted mid-request (WAIT or IDLE capture) aborts the request: no write occurs and Done never pulses for it.
- A request that drops in WAIT is a core protocol violation. The block completes using the captured values.

## Test plan
- WAIT_CYCLES = 2: sw 0xDEADBEEF @0x10, then lw @0x10 → Stall high 3 cycles each, Done in cycle 3, RdData = 0xDEADBEEF.
- sb 0x80 @0x13 over word 0x00000000, then lb @0x13 → RdData = 0xFFFFFF80; lbu → 0x00000080; lw @0x10 → 0x80000000.
- sh 0x8001 @0x22, then lh @0x22 → 0xFFFF8001; lhu → 0x00008001; lower half of the word is unchanged.
- lw @0x11 and sh @0x23 → AccErr and Done pulse together; memory unchanged; the load's RdData = 0. MemRead = MemWrite = 1 → AccErr, no write.
- WAIT_CYCLES = 0: Done in the cycle after the request. Two back-to-back lw → Done in cycles 1 and 3.
- Reset pulsed in WAIT of sw @0x30 → no Done; later lw @0x30 returns the previous contents.
